// File: rtl/tb_dispatch_pkg.sv
// Shared types and helpers for the testbench command dispatcher: FSM states,
// the "no command" id and a one-hot slot decoder.
package tb_dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        WAIT_DONE,
        ACK
    } state_t;

    localparam int ID_W       = 16;
    localparam int ONEHOT_MAX = 64;

    localparam logic [ID_W-1:0] CMD_ID_NONE = '1;

    // Returns zero for any id outside 0..cmd_nb-1, which doubles as the illegal-id test.
    function automatic logic [ONEHOT_MAX-1:0] onehot(input logic [ID_W-1:0] id,
                                                     input int cmd_nb);
        logic [ONEHOT_MAX-1:0] vec;
        vec = '0;
        if (id != CMD_ID_NONE) begin
            for (int i = 0; i < ONEHOT_MAX; i++) begin
                if (i < cmd_nb && ID_W'(i) == id) begin
                    vec[i] = 1'b1;
                end
            end
        end
        return vec;
    endfunction

endpackage

// File: rtl/tb_watchdog_cnt.sv
// Per-command watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches LIMIT-1. LIMIT=0 never expires.
module tb_watchdog_cnt #(
    parameter int LIMIT = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int              CW     = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam bit              ACTIVE = (LIMIT > 0);
    localparam logic [CW-1:0]   LAST   = ACTIVE ? CW'(LIMIT - 1) : '0;

    logic [CW-1:0] cnt_reg;

    // Saturates at LAST so a stuck enable cannot wrap into a false early expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (enable && cnt_reg != LAST) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign expire = ACTIVE && enable && (cnt_reg == LAST);

endmodule

// File: rtl/tb_cmd_dispatcher.sv
// Dispatches one decoded command per sequencer step to a one-hot executor
// select, waits for done (with watchdog), then acks and counts the step.
module tb_cmd_dispatcher
    import tb_dispatch_pkg::*;
#(
    parameter int CMD_NB         = 8,
    parameter int CMD_W          = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CMD_W-1:0]  i_cmd_id,
    input  logic              i_cmd_valid,
    input  logic [CMD_NB-1:0] i_blocking,
    input  logic [CMD_NB-1:0] i_done,
    output logic [CMD_NB-1:0] o_sel,
    output logic              o_ack,
    output logic              o_busy,
    output logic              o_timeout,
    output logic              o_err_id,
    output logic              o_overrun,
    output logic [CNT_W-1:0]  o_cmd_cnt
);

    state_t                state_reg, state_next;
    logic [CMD_NB-1:0]     slot_reg, slot_next;
    logic [ONEHOT_MAX-1:0] cmd_oh;
    logic                  err_next, timeout_next;
    logic                  wd_clear, wd_en, wd_expire;

    logic [CMD_NB-1:0]     sel_reg;
    logic                  ack_reg, busy_reg, timeout_reg, err_reg, overrun_reg;
    logic [CNT_W-1:0]      cnt_reg;

    assign wd_clear = (state_reg == DISPATCH);
    assign wd_en    = (state_reg == WAIT_DONE);

    tb_watchdog_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wd_clear),
        .enable (wd_en),
        .expire (wd_expire)
    );

    always_comb begin
        cmd_oh       = onehot(ID_W'(i_cmd_id), CMD_NB);
        state_next   = state_reg;
        slot_next    = slot_reg;
        err_next     = 1'b0;
        timeout_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_cmd_valid) begin
                    slot_next = cmd_oh[CMD_NB-1:0];
                    if (cmd_oh == '0) begin
                        state_next = ACK;
                        err_next   = 1'b1;
                    end else begin
                        state_next = DISPATCH;
                    end
                end
            end
            DISPATCH: begin
                state_next = (|(i_blocking & slot_reg)) ? WAIT_DONE : ACK;
            end
            WAIT_DONE: begin
                // Done has priority over a coincident watchdog expiry.
                if (|(i_done & slot_reg)) begin
                    state_next = ACK;
                end else if (wd_expire) begin
                    state_next   = ACK;
                    timeout_next = 1'b1;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            slot_reg    <= '0;
            sel_reg     <= '0;
            ack_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            err_reg     <= 1'b0;
            overrun_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            slot_reg    <= slot_next;
            sel_reg     <= (state_next == DISPATCH || state_next == WAIT_DONE) ? slot_next : '0;
            ack_reg     <= (state_next == ACK);
            busy_reg    <= (state_next != IDLE);
            timeout_reg <= timeout_next;
            err_reg     <= err_next;
            overrun_reg <= i_cmd_valid && (state_reg != IDLE);
            if (state_next == ACK) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign o_sel     = sel_reg;
    assign o_ack     = ack_reg;
    assign o_busy    = busy_reg;
    assign o_timeout = timeout_reg;
    assign o_err_id  = err_reg;
    assign o_overrun = overrun_reg;
    assign o_cmd_cnt = cnt_reg;

    a_sel_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(o_sel));
    a_ack_no_sel  : assert property (@(posedge clk) disable iff (!rst_n) !(o_ack && (o_sel != '0)));

endmodule

// File: tb/tb_tb_cmd_dispatcher.sv
// Directed bench for tb_cmd_dispatcher: expected acks are queued when commands
// are driven and matched by a monitor whenever the DUT acks.
module tb_tb_cmd_dispatcher;

    localparam int CMD_NB = 8;
    localparam int CMD_W  = 4;
    localparam int TMO    = 20;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CMD_W-1:0]  i_cmd_id;
    logic              i_cmd_valid;
    logic [CMD_NB-1:0] i_blocking;
    logic [CMD_NB-1:0] i_done;
    logic [CMD_NB-1:0] o_sel;
    logic              o_ack;
    logic              o_busy;
    logic              o_timeout;
    logic              o_err_id;
    logic              o_overrun;
    logic [CNT_W-1:0]  o_cmd_cnt;

    typedef struct packed {
        logic        err;
        logic        timeout;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_cnt = 0;

    always #5 clk = ~clk;

    tb_cmd_dispatcher #(
        .CMD_NB         (CMD_NB),
        .CMD_W          (CMD_W),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cmd_id    (i_cmd_id),
        .i_cmd_valid (i_cmd_valid),
        .i_blocking  (i_blocking),
        .i_done      (i_done),
        .o_sel       (o_sel),
        .o_ack       (o_ack),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout),
        .o_err_id    (o_err_id),
        .o_overrun   (o_overrun),
        .o_cmd_cnt   (o_cmd_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ack(input logic err, input logic tmo);
        exp_t e;
        exp_cnt   = exp_cnt + 1;
        e.err     = err;
        e.timeout = tmo;
        e.cnt     = exp_cnt;
        sb_q.push_back(e);
    endtask

    task automatic send(input logic [CMD_W-1:0] id);
        i_cmd_id    = id;
        i_cmd_valid = 1'b1;
        step();
        i_cmd_valid = 1'b0;
        $display("cmd id=%0d sel=%02h ack=%0b err=%0b cnt=%0d", id, o_sel, o_ack, o_err_id, o_cmd_cnt);
    endtask

    // Scoreboard side: every ack must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && o_ack === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("ack_unexpected", 32'(o_ack), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("ack_err",     32'(o_err_id),  32'(e.err));
                check("ack_timeout", 32'(o_timeout), 32'(e.timeout));
                check("ack_cnt",     o_cmd_cnt,      e.cnt);
                check("ack_sel",     32'(o_sel),     32'd0);
                $display("ack err=%0b timeout=%0b cnt=%0d", o_err_id, o_timeout, o_cmd_cnt);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        i_cmd_id    = '0;
        i_cmd_valid = 1'b0;
        i_blocking  = '0;
        i_done      = '0;
        repeat (3) step();
        check("rst_sel",     32'(o_sel),     32'd0);
        check("rst_ack",     32'(o_ack),     32'd0);
        check("rst_busy",    32'(o_busy),    32'd0);
        check("rst_flags",   32'({o_timeout, o_err_id, o_overrun}), 32'd0);
        check("rst_cnt",     o_cmd_cnt,      32'd0);
        rst_n = 1'b1;
        step();

        // Non-blocking id 2: sel for one cycle, ack next
        expect_ack(1'b0, 1'b0);
        send(4'd2);
        check("nb_sel",  32'(o_sel),  32'h04);
        check("nb_busy", 32'(o_busy), 32'd1);
        check("nb_ack0", 32'(o_ack),  32'd0);
        step();
        check("nb_sel_low", 32'(o_sel),  32'd0);
        check("nb_ack",     32'(o_ack),  32'd1);
        check("nb_cnt",     o_cmd_cnt,   32'd1);
        step();
        check("nb_ack_end",  32'(o_ack),  32'd0);
        check("nb_busy_end", 32'(o_busy), 32'd0);

        // Blocking id 5 with done ten cycles after sel
        i_blocking = 8'h20;
        expect_ack(1'b0, 1'b0);
        send(4'd5);
        for (int k = 1; k <= 10; k++) begin
            check("blk_hold_sel", 32'(o_sel), 32'h20);
            check("blk_hold_ack", 32'(o_ack), 32'd0);
            step();
        end
        i_done = 8'h20;
        step();
        i_done = '0;
        check("blk_sel_low", 32'(o_sel),     32'd0);
        check("blk_ack",     32'(o_ack),     32'd1);
        check("blk_no_tmo",  32'(o_timeout), 32'd0);
        check("blk_cnt",     o_cmd_cnt,      32'd2);
        step();

        // Blocking id 1, no done: foreign done and overrun injected while waiting
        i_blocking = 8'h02;
        expect_ack(1'b0, 1'b1);
        send(4'd1);
        for (int k = 1; k <= TMO; k++) begin
            if (k == 5) i_done = 8'h08;
            if (k == 8) begin
                i_cmd_id    = 4'd3;
                i_cmd_valid = 1'b1;
            end
            step();
            i_done      = '0;
            i_cmd_valid = 1'b0;
            check("tmo_wait_sel", 32'(o_sel),     32'h02);
            check("tmo_wait_ack", 32'(o_ack),     32'd0);
            check("tmo_overrun",  32'(o_overrun), (k == 8) ? 32'd1 : 32'd0);
        end
        step();
        check("tmo_ack",     32'(o_ack),     32'd1);
        check("tmo_flag",    32'(o_timeout), 32'd1);
        check("tmo_sel_low", 32'(o_sel),     32'd0);
        step();
        check("tmo_flag_end", 32'(o_timeout), 32'd0);

        // Done on the expiry cycle wins over the watchdog
        expect_ack(1'b0, 1'b0);
        send(4'd1);
        for (int k = 1; k <= TMO; k++) begin
            step();
        end
        i_done = 8'h02;
        step();
        i_done = '0;
        check("race_ack", 32'(o_ack),     32'd1);
        check("race_tmo", 32'(o_timeout), 32'd0);
        step();

        // Illegal id 9: immediate error ack, no select
        expect_ack(1'b1, 1'b0);
        send(4'd9);
        check("ill_ack", 32'(o_ack),    32'd1);
        check("ill_err", 32'(o_err_id), 32'd1);
        check("ill_sel", 32'(o_sel),    32'd0);
        check("ill_cnt", o_cmd_cnt,     32'd5);
        step();
        check("ill_err_end", 32'(o_err_id), 32'd0);
        check("ill_sel_end", 32'(o_sel),    32'd0);

        // Reset while waiting on a blocking command
        send(4'd1);
        repeat (3) step();
        check("pre_rst_sel", 32'(o_sel), 32'h02);
        #3;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check("arst_sel",  32'(o_sel),  32'd0);
        check("arst_cnt",  o_cmd_cnt,   32'd0);
        check("arst_busy", 32'(o_busy), 32'd0);
        check("arst_ack",  32'(o_ack),  32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("post_rst_ack", 32'(o_ack), 32'd0);

        // New command accepted normally after reset
        i_blocking = '0;
        expect_ack(1'b0, 1'b0);
        send(4'd0);
        check("post_sel", 32'(o_sel), 32'h01);
        step();
        check("post_ack", 32'(o_ack), 32'd1);
        check("post_cnt", o_cmd_cnt,  32'd1);
        repeat (3) step();

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tb_cmd_dispatcher.md
Name: tb_cmd_dispatcher

Overview:
- Sequences the testbench command executors (set injector, wait event, check level, wait duration, and later additions).
- Takes one decoded command id per sequencer step, one-hot selects the matching executor and holds the select until that executor reports done.
- Then returns a single ack pulse to the sequencer.
- Adds a per-command timeout watchdog, illegal-id and overrun detection, and a completed-command counter, so a hung executor cannot stall a scenario silently.

Parameters:
- CMD_NB, 8, number of executor slots.
- CMD_W, 4, width of command id; must satisfy 2**CMD_W >= CMD_NB+1.
- TIMEOUT_CYCLES, 100000, clock cycles allowed in WAIT_DONE; 0 disables the watchdog.
- CNT_W, 32, width of the completed-command counter.

Ports:
- clk  in  1  testbench clock.
- rst_n  in  1  asynchronous active-low reset.
- i_cmd_id  in  CMD_W  decoded command id, sampled when i_cmd_valid=1.
- i_cmd_valid  in  1  one-cycle pulse: new command available.
- i_blocking  in  CMD_NB  per-slot flag, static during a scenario: 1 = slot returns done, 0 = fire-and-forget.
- i_done  in  CMD_NB  per-slot done pulse from the executors.
- o_sel  out  CMD_NB  one-hot executor select, level.
- o_ack  out  1  one-cycle pulse to the sequencer: step finished.
- o_busy  out  1  high from acceptance until the ack cycle, inclusive.
- o_timeout  out  1  one-cycle pulse, coincident with o_ack, on watchdog expiry.
- o_err_id  out  1  one-cycle pulse, coincident with o_ack, for id >= CMD_NB.
- o_overrun  out  1  one-cycle pulse when i_cmd_valid arrives while busy.
- o_cmd_cnt  out  CNT_W  number of acks issued since reset.

Behaviour:
- Reset: asynchronous, active-low. All outputs are 0, the FSM is in IDLE, and the watchdog and o_cmd_cnt are cleared. Reset mid-command drops o_sel immediately and does not ack.
- All outputs are registered.
- FSM states:
  - IDLE: on i_cmd_valid, latch id and go to DISPATCH. For an illegal id, go to ACK with the error flag set.
  - DISPATCH: set o_sel[id]. If i_blocking[id]=0, go to ACK. Otherwise clear the watchdog and go to WAIT_DONE.
  - WAIT_DONE: hold o_sel. On i_done[id], go to ACK. If the watchdog reaches TIMEOUT_CYCLES-1 without done, go to ACK with the timeout flag set.
  - ACK: o_sel=0, o_ack=1, error/timeout pulses asserted, o_cmd_cnt+1; next state IDLE.
- Latency, with valid sampled at edge N:
  - Non-blocking: o_sel high during cycle N+1 only; o_ack at N+2.
  - Blocking: done sampled at edge M gives o_sel low and o_ack at M+1.
  - Illegal id: o_ack and o_err_id at N+1; o_sel never asserted.
- i_done bits of non-selected slots are ignored. A done in the same cycle as watchdog expiry wins: normal ack, no timeout.
- i_done arriving in the DISPATCH cycle itself is ignored; executors respond no earlier than one cycle after seeing sel.
- A new command is accepted in IDLE only. i_cmd_valid in DISPATCH, WAIT_DONE or ACK pulses o_overrun the next cycle and the command is discarded. Back-to-back throughput is therefore one command per 3 cycles minimum.
- o_cmd_cnt wraps modulo 2**CNT_W. Ack counts include error and timeout acks.
- Watchdog: CNT width is $clog2(TIMEOUT_CYCLES+1). It counts only in WAIT_DONE. With TIMEOUT_CYCLES=0, WAIT_DONE waits indefinitely.
- Simulation-only assertions:
  - o_sel is one-hot or zero.
  - o_ack never coincides with o_sel!=0.

Decomposition:
- Package tb_dispatch_pkg:
  - state enum {IDLE, DISPATCH, WAIT_DONE, ACK}.
  - constant CMD_ID_NONE = all-ones.
  - function onehot(id, CMD_NB).
- Sub-module tb_watchdog_cnt: clear, enable, expire output, parameter LIMIT, LIMIT=0 never expires. It is instantiated once.
- The FSM, select, counter and flag logic stay in tb_cmd_dispatcher.

Test Plan:
- Non-blocking: i_blocking=0, id=2 pulsed at N -> o_sel=8'h04 at N+1 only, o_ack at N+2, o_cmd_cnt=1.
- Blocking: i_blocking[5]=1, id=5, i_done[5] pulsed 10 cycles after sel -> sel held 10+ cycles, o_ack next cycle, no timeout.
- Timeout: TIMEOUT_CYCLES=20, blocking id=1, no done -> o_ack and o_timeout together after 20 WAIT_DONE cycles; o_sel low on that cycle. Repeat with done on the expiry cycle -> o_timeout stays 0.
- Illegal id: id=9 with CMD_NB=8 -> o_ack and o_err_id at N+1, o_sel stays 0, o_cmd_cnt increments.
- Overrun and foreign done: valid during WAIT_DONE -> o_overrun pulse, command dropped. i_done[3] while sel[1] -> ignored, still waiting.
- Reset mid-WAIT_DONE: rst_n low -> o_sel=0 and o_cmd_cnt=0 asynchronously, no o_ack. After release, a new command is accepted normally.
